// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : UART receiver with 16x oversampling. It finds the start bit on a
//            falling edge and confirms it at mid-bit. It then samples each data
//            bit (LSB first) at mid-bit and checks the stop bit at mid-stop.
//            The receiver returns to idle at mid-stop, so frames with no idle
//            bits between them are received correctly.
//
// Ports    : clk          system clock, rising edge
//            rst          synchronous active-high reset
//            baud_en_16x  one-clk tick at 16x the baud rate
//            rxd          asynchronous serial input, idle high
//            rx_ready     consumer accepts rx_data while rx_valid is high
//            rx_data      received word (DATA_BITS wide)
//            rx_valid     rx_data holds an unconsumed word
//            frame_err    one-clk pulse: stop bit sampled low
//            overrun_err  one-clk pulse: good frame dropped, holding register full
//            parity_err   one-clk pulse: even-parity mismatch
//
// Config   : UART_RX_PARITY_EN -- when defined, one even-parity bit sits
//            between the data bits and the stop bit. When undefined,
//            parity_err is tied to 0.
//
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_en_16x,
  input  logic                 rxd,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 parity_err
);

  localparam logic [2:0] c_LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic [3:0] c_MID_TICK = 4'd7;   // 8th tick after the falling edge
  localparam logic [3:0] c_END_TICK = 4'd15;  // 16th tick: one bit period on

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY    = 3'd3,
`endif
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_rxd_meta;
  logic                 r_rxd_sync;
  logic [3:0]           r_tick;
  logic [3:0]           w_tick_nxt;
  logic [2:0]           r_bit;
  logic [2:0]           w_bit_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 w_good;
  logic                 w_ferr;

  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_overrun_err;

`ifdef UART_RX_PARITY_EN
  logic                 r_par_bit;
  logic                 w_par_nxt;
  logic                 w_perr;
  logic                 r_parity_err;
`endif

  // --------------------------------------------------------------------------
  // Input synchronizer. It resets to the idle-line level so that reset does
  // not look like a start bit.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
    end else begin
      r_rxd_meta <= rxd;
      r_rxd_sync <= r_rxd_meta;
    end
  end

  // --------------------------------------------------------------------------
  // State register and sampling datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tick  <= 4'd0;
      r_bit   <= 3'd0;
      r_shift <= '0;
`ifdef UART_RX_PARITY_EN
      r_par_bit <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
`ifdef UART_RX_PARITY_EN
      r_par_bit <= w_par_nxt;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Nothing moves except on a baud tick.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_good      = 1'b0;
    w_ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_nxt   = r_par_bit;
    w_perr      = 1'b0;
`endif
    if (baud_en_16x) begin
      w_tick_nxt = r_tick + 4'd1;
      case (r_state)
        S_IDLE: begin
          w_tick_nxt = 4'd0;
          if (!r_rxd_sync) begin
            w_state_nxt = S_START;
          end
        end
        S_START: begin
          // Confirm at mid-start. A line that is high again here was a glitch.
          if (r_tick == c_MID_TICK) begin
            w_tick_nxt  = 4'd0;
            w_bit_nxt   = 3'd0;
            w_state_nxt = r_rxd_sync ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (r_tick == c_END_TICK) begin
            w_shift_nxt = {r_rxd_sync, r_shift[DATA_BITS-1:1]};
            w_bit_nxt   = r_bit + 3'd1;
            if (r_bit == c_LAST_BIT) begin
              w_bit_nxt = 3'd0;
`ifdef UART_RX_PARITY_EN
              w_state_nxt = S_PARITY;
`else
              w_state_nxt = S_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (r_tick == c_END_TICK) begin
            w_par_nxt   = r_rxd_sync;
            w_state_nxt = S_STOP;
          end
        end
`endif
        S_STOP: begin
          // Leave at mid-stop. The rest of the stop bit is spent in IDLE, so
          // the next start edge can come right after it.
          if (r_tick == c_END_TICK) begin
            w_ferr      = ~r_rxd_sync;
            w_state_nxt = r_rxd_sync ? S_IDLE : S_WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
            w_perr = (r_par_bit != ^r_shift);
            w_good = r_rxd_sync & ~w_perr;
`else
            w_good = r_rxd_sync;
`endif
          end
        end
        S_WAIT_HIGH: begin
          // A held-low break must not be taken as a new start bit.
          w_tick_nxt = 4'd0;
          if (r_rxd_sync) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_tick_nxt  = 4'd0;
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Holding register and error pulses
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data        <= '0;
      r_valid       <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err  <= 1'b0;
`endif
    end else begin
      r_frame_err   <= w_ferr;
      r_overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err  <= w_perr;
`endif
      if (w_good) begin
        // The register can be refilled in the same cycle the consumer drains it.
        if (!r_valid || rx_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun_err <= 1'b1;
        end
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data     = r_data;
  assign rx_valid    = r_valid;
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun_err;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = r_parity_err;
`else
  assign parity_err  = 1'b0;
`endif

endmodule
`default_nettype wire
